// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
// Native memory bus between a core (master) and a memory target (slave).
//   mem_valid  master->slave  request present, fields held until mem_ready
//   mem_instr  master->slave  instruction-fetch tag
//   mem_addr   master->slave  byte address (bits [1:0] ignored by the target)
//   mem_wdata  master->slave  write data, byte lanes selected by mem_wstrb
//   mem_wstrb  master->slave  byte write enables, 4'b0000 means read
//   mem_rdata  slave->master  read data, valid while mem_ready=1
//   mem_ready  slave->master  one-cycle completion pulse
//   mem_err    slave->master  error flag, qualified by mem_ready
// ---------------------------------------------------------------------------
interface mem_responder_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_err;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready, mem_err
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready, mem_err
    );
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Word-organised on-chip RAM answering the core's native memory interface,
// one request at a time, after LATENCY cycles.
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    mem_responder_if.slave (valid/instr/addr/wdata/wstrb -> rdata/ready/err)
//
// Parameters:
//   DEPTH      number of 32-bit words (power of two, >= 4)
//   BASE_ADDR  byte address of word 0 (aligned to DEPTH*4)
//   LATENCY    cycles from acceptance to mem_ready (1..15)
//
// Optional feature macro: MEM_RANGE_CHECK_EN
//   Defined:   out-of-window addresses and instruction-tagged writes are
//              flagged on mem_err, never write RAM and return zero data.
//   Undefined: addresses wrap modulo DEPTH*4 and mem_err is tied low.
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LATENCY   = 1
) (
    input  logic           clock,
    input  logic           reset,
    mem_responder_if.slave bus
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    // Wait counter preload; the WAIT state is skipped entirely for LATENCY==1.
    localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_cnt;
    logic [3:0]        w_next_cnt;
    logic [31:0]       r_hold;
    logic              r_ready;
    logic [31:0]       r_rdata;

    logic [31:0]       r_mem [DEPTH];

    logic [31:0]       w_offset;
    logic [IDX_W-1:0]  w_idx;
    logic              w_is_write;
    logic              w_accept;
    logic              w_err;
    logic [31:0]       w_rd_word;
    logic [31:0]       w_acc_data;
    logic [31:0]       w_resp_data;
    logic              w_unused;

    // Subtracting the base first and then slicing gives the modulo wrap.
    assign w_offset   = bus.mem_addr - BASE_ADDR;
    assign w_idx      = w_offset[IDX_W+1:2];
    assign w_is_write = (bus.mem_wstrb != 4'b0000);
    assign w_accept   = (r_state == ST_IDLE) && bus.mem_valid;
    assign w_rd_word  = r_mem[w_idx];

    // Address bits above the window and the byte offset carry no meaning here.
    assign w_unused   = &{1'b0, w_offset[31:IDX_W+2], w_offset[1:0], bus.mem_instr};

`ifdef MEM_RANGE_CHECK_EN
    // 33-bit end address so a window reaching the top of the map cannot overflow.
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH) * 33'd4);

    logic r_hold_err;
    logic r_err;
    logic w_resp_err;

    assign w_err = ({1'b0, bus.mem_addr} < {1'b0, BASE_ADDR})
                || ({1'b0, bus.mem_addr} >= END_ADDR)
                || (bus.mem_instr && w_is_write);

    assign w_resp_err = (r_state == ST_IDLE) ? w_err : r_hold_err;

    // Error flag travels with the access and is presented alongside mem_ready.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hold_err <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold_err <= w_err;
            end
            r_err <= (w_next_state == ST_RESP) ? w_resp_err : 1'b0;
        end
    end

    assign bus.mem_err = r_err;
`else
    assign w_err       = 1'b0;
    assign bus.mem_err = 1'b0;
`endif

    // Reads and writes both answer with zero data when flagged as errors.
    assign w_acc_data  = (w_is_write || w_err) ? 32'h0000_0000 : w_rd_word;
    // With LATENCY==1 the response is built straight from the accept cycle.
    assign w_resp_data = (r_state == ST_IDLE) ? w_acc_data : r_hold;

    // RAM write port: only enabled byte lanes change, committed at acceptance.
    always_ff @(posedge clock) begin
        if (!reset && w_accept && w_is_write && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.mem_valid) begin
                    if (LATENCY == 1) begin
                        w_next_state = ST_RESP;
                    end else begin
                        w_next_state = ST_WAIT;
                        w_next_cnt   = CNT_INIT;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // mem_valid is deliberately not looked at while waiting.
                if (r_cnt == 4'd0) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    // State register, read-data holding register and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_hold  <= 32'h0000_0000;
            r_ready <= 1'b0;
            r_rdata <= 32'h0000_0000;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_hold <= w_acc_data;
            end
            r_ready <= (w_next_state == ST_RESP);
            r_rdata <= (w_next_state == ST_RESP) ? w_resp_data : 32'h0000_0000;
        end
    end

    assign bus.mem_ready = r_ready;
    assign bus.mem_rdata = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Two responders (LATENCY=1 and LATENCY=4) share clock and reset. Each request
// pushes its expected {err, rdata} into a per-instance queue; a negedge
// monitor pops and compares whenever mem_ready is seen.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam int DEPTH = 4096;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    mem_responder_if b1 ();
    mem_responder_if b4 ();

    mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000), .LATENCY(1)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (b1.slave)
    );

    mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000), .LATENCY(4)) u_dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (b4.slave)
    );

    logic        drv_valid [2];
    logic        drv_instr [2];
    logic [31:0] drv_addr  [2];
    logic [31:0] drv_wdata [2];
    logic [3:0]  drv_wstrb [2];
    logic        obs_ready [2];
    logic [31:0] obs_rdata [2];
    logic        obs_err   [2];

    assign b1.mem_valid = drv_valid[0];
    assign b1.mem_instr = drv_instr[0];
    assign b1.mem_addr  = drv_addr[0];
    assign b1.mem_wdata = drv_wdata[0];
    assign b1.mem_wstrb = drv_wstrb[0];
    assign b4.mem_valid = drv_valid[1];
    assign b4.mem_instr = drv_instr[1];
    assign b4.mem_addr  = drv_addr[1];
    assign b4.mem_wdata = drv_wdata[1];
    assign b4.mem_wstrb = drv_wstrb[1];
    assign obs_ready[0] = b1.mem_ready;
    assign obs_rdata[0] = b1.mem_rdata;
    assign obs_err[0]   = b1.mem_err;
    assign obs_ready[1] = b4.mem_ready;
    assign obs_rdata[1] = b4.mem_rdata;
    assign obs_err[1]   = b4.mem_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [32:0] sbq0 [$];
    logic [32:0] sbq1 [$];
    logic [31:0] model [2][DEPTH];
    logic        prev_ready0 = 1'b0;
    logic        prev_ready1 = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives a request and records its expected outcome from the reference model.
    task automatic start_req(input int sel, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input logic instr);
        int          idx;
        logic        err;
        logic [31:0] exp;
        idx = int'(addr[13:2]);
        err = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
        err = (addr >= 32'(DEPTH * 4)) || (instr && (wstrb != 4'b0000));
`endif
        exp = 32'h0000_0000;
        if (!err) begin
            if (wstrb == 4'b0000) begin
                exp = model[sel][idx];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) model[sel][idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
        if (sel == 0) sbq0.push_back({err, exp});
        else          sbq1.push_back({err, exp});
        drv_valid[sel] = 1'b1;
        drv_instr[sel] = instr;
        drv_addr[sel]  = addr;
        drv_wdata[sel] = wdata;
        drv_wstrb[sel] = wstrb;
    endtask

    // One complete access with a bounded wait for mem_ready and a latency check.
    task automatic access(input int sel, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic instr);
        int waited;
        @(negedge clock);
        start_req(sel, addr, wdata, wstrb, instr);
        @(posedge clock);
        waited = 0;
        @(negedge clock);
        while (!obs_ready[sel] && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        check_eq((sel == 0) ? "latency_l1" : "latency_l4", 64'(waited + 1), (sel == 0) ? 64'd1 : 64'd4);
        drv_valid[sel] = 1'b0;
    endtask

    // Three reads with mem_valid held high throughout on the LATENCY=4 instance.
    task automatic b2b_reads();
        int          k;
        int          seen [3];
        logic [31:0] addrs [3];
        addrs[0] = 32'h40; addrs[1] = 32'h44; addrs[2] = 32'h48;
        seen[0] = 0; seen[1] = 0; seen[2] = 0;
        k = 0;
        @(negedge clock);
        start_req(1, addrs[0], 32'h0, 4'b0000, 1'b0);
        for (int n = 1; n <= 18; n++) begin
            @(negedge clock);
            if (obs_ready[1]) begin
                if (k < 3) seen[k] = n;
                k++;
                if (k < 3) start_req(1, addrs[k], 32'h0, 4'b0000, 1'b0);
                else       drv_valid[1] = 1'b0;
            end
        end
        check_eq("b2b_count", 64'(k), 64'd3);
        check_eq("b2b_t0", 64'(seen[0]), 64'd4);
        check_eq("b2b_t1", 64'(seen[1]), 64'd9);
        check_eq("b2b_t2", 64'(seen[2]), 64'd14);
    endtask

    // Scoreboard monitor: every ready pulse must match the oldest expectation.
    always @(negedge clock) begin
        logic [32:0] e;
        if (!reset) begin
            if (obs_ready[0]) begin
                check_eq("ready_width_l1", 64'(prev_ready0), 64'd0);
                check_eq("sb_nonempty_l1", 64'(sbq0.size() != 0), 64'd1);
                if (sbq0.size() != 0) begin
                    e = sbq0.pop_front();
                    check_eq("rdata_l1", 64'(obs_rdata[0]), 64'(e[31:0]));
                    check_eq("err_l1", 64'(obs_err[0]), 64'(e[32]));
                end
            end else begin
                check_eq("idle_rdata_l1", 64'(obs_rdata[0]), 64'd0);
            end
            if (obs_ready[1]) begin
                check_eq("ready_width_l4", 64'(prev_ready1), 64'd0);
                check_eq("sb_nonempty_l4", 64'(sbq1.size() != 0), 64'd1);
                if (sbq1.size() != 0) begin
                    e = sbq1.pop_front();
                    check_eq("rdata_l4", 64'(obs_rdata[1]), 64'(e[31:0]));
                    check_eq("err_l4", 64'(obs_err[1]), 64'(e[32]));
                end
            end else begin
                check_eq("idle_rdata_l4", 64'(obs_rdata[1]), 64'd0);
            end
        end
        prev_ready0 <= obs_ready[0];
        prev_ready1 <= obs_ready[1];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            drv_valid[s] = 1'b0;
            drv_instr[s] = 1'b0;
            drv_addr[s]  = 32'h0;
            drv_wdata[s] = 32'h0;
            drv_wstrb[s] = 4'b0000;
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("rst_ready_l1", 64'(obs_ready[0]), 64'd0);
        check_eq("rst_rdata_l1", 64'(obs_rdata[0]), 64'd0);
        check_eq("rst_err_l1", 64'(obs_err[0]), 64'd0);
        check_eq("rst_ready_l4", 64'(obs_ready[1]), 64'd0);
        check_eq("rst_cnt_l4", 64'(u_dut4.r_cnt), 64'd0);
        reset = 1'b0;

        // Write then read, LATENCY=1.
        access(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
        access(0, 32'h10, 32'h0, 4'b0000, 1'b0);
        // Byte lanes 0 and 2 only.
        access(0, 32'h20, 32'h1122_3344, 4'hF, 1'b0);
        access(0, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0);
        access(0, 32'h20, 32'h0, 4'b0000, 1'b0);
`ifndef MEM_RANGE_CHECK_EN
        // Address wrap modulo DEPTH*4.
        access(0, 32'h4004, 32'h5A5A_5A5A, 4'hF, 1'b0);
        access(0, 32'h0004, 32'h0, 4'b0000, 1'b0);
`else
        access(0, 32'h4000, 32'h0, 4'b0000, 1'b0);
        access(0, 32'h8, 32'h0102_0304, 4'hF, 1'b0);
        access(0, 32'h8, 32'hFFFF_FFFF, 4'hF, 1'b1);
        access(0, 32'h8, 32'h0, 4'b0000, 1'b0);
`endif
        // Instruction-tagged read behaves like any read.
        access(0, 32'h10, 32'h0, 4'b0000, 1'b1);

        // LATENCY=4: preload, then back-to-back reads.
        access(1, 32'h40, 32'hA0A0_0001, 4'hF, 1'b0);
        access(1, 32'h44, 32'hA0A0_0002, 4'hF, 1'b0);
        access(1, 32'h48, 32'hA0A0_0003, 4'hF, 1'b0);
        b2b_reads();

        // Reset two cycles into WAIT aborts the read.
        access(1, 32'h30, 32'hC0FF_EE00, 4'hF, 1'b0);
        @(negedge clock);
        start_req(1, 32'h30, 32'h0, 4'b0000, 1'b0);
        @(posedge clock);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        drv_valid[1] = 1'b0;
        sbq1.delete();
        @(negedge clock);
        check_eq("rst_wait_ready", 64'(obs_ready[1]), 64'd0);
        check_eq("rst_wait_state", 64'(u_dut4.r_state), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check_eq("post_rst_ready", 64'(obs_ready[1]), 64'd0);
        end
        access(1, 32'h30, 32'h0, 4'b0000, 1'b0);

        repeat (3) @(negedge clock);
        check_eq("sb_drained", 64'(sbq0.size() + sbq1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
